// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
// Host IDs are sized for the largest supported host count so every configuration shares one tag width.
package ram_arb_pkg;

    localparam int MaxHosts = 4;
    localparam int HostIdW  = $clog2(MaxHosts);

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or above ptr_i, wrapping. Purely combinational, zero latency.
// No backpressure; a host that is not granted simply keeps requesting.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NumHosts = 2
) (
    input  logic [NumHosts-1:0] req_i,
    input  logic [HostIdW-1:0]  ptr_i,
    output logic [NumHosts-1:0] gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < NumHosts; k++) begin
            for (int h = 0; h < NumHosts; h++) begin
                if (!found && req_i[h] && (h == (int'(ptr_i) + k) % NumHosts)) begin
                    gnt_o[h] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arb.sv
// Shares one RAM port among NumHosts requesters (round-robin, same-cycle grant, 1-cycle response routing)
// and runs a full-RAM zero sweep on request; hosts stall (hold req) while the sweep owns the port.
module ram_port_arb
    import ram_arb_pkg::*;
#(
    parameter int NumHosts = 2,
    parameter int Depth    = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumHosts-1:0]      host_req_i,
    input  logic [NumHosts-1:0]      host_we_i,
    input  logic [NumHosts-1:0][3:0] host_be_i,
    input  logic [NumHosts-1:0][31:0] host_addr_i,
    input  logic [NumHosts-1:0][31:0] host_wdata_i,
    output logic [NumHosts-1:0]      host_gnt_o,
    output logic [NumHosts-1:0]      host_rvalid_o,
    output logic [31:0]              host_rdata_o,
    output logic                     ram_req_o,
    output logic                     ram_we_o,
    output logic [3:0]               ram_be_o,
    output logic [31:0]              ram_addr_o,
    output logic [31:0]              ram_wdata_o,
    input  logic                     ram_rvalid_i,
    input  logic [31:0]              ram_rdata_i,
    input  logic                     clr_req_i,
    output logic                     clr_busy_o,
    output logic                     clr_done_o
);

    localparam int CntW = (Depth > 1) ? $clog2(Depth) : 1;

    arb_state_e          state;
    logic [HostIdW-1:0]  rr_ptr;
    logic [HostIdW-1:0]  tag_id;
    logic                tag_vld;
    logic [CntW-1:0]     clr_cnt;
    logic                clr_done;
    logic [NumHosts-1:0] arb_gnt;
    logic [HostIdW-1:0]  gnt_id;

    rr_arbiter #(.NumHosts(NumHosts)) u_rr (
        .req_i (host_req_i),
        .ptr_i (rr_ptr),
        .gnt_o (arb_gnt)
    );

    assign host_gnt_o   = (state == RUN && !rst_i) ? arb_gnt : '0;
    assign clr_busy_o   = (state == CLEAR) && !rst_i;
    assign clr_done_o   = clr_done && !rst_i;
    assign host_rdata_o = ram_rdata_i;

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NumHosts; i++) begin
            if (arb_gnt[i]) gnt_id = HostIdW'(i);
        end
    end

    // The sweep owns the port outright; otherwise the granted host drives it straight through.
    always_comb begin
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (clr_busy_o) begin
            ram_req_o  = 1'b1;
            ram_we_o   = 1'b1;
            ram_be_o   = 4'hF;
            ram_addr_o = 32'(clr_cnt) << 2;
        end else begin
            for (int i = 0; i < NumHosts; i++) begin
                if (host_gnt_o[i]) begin
                    ram_req_o   = 1'b1;
                    ram_we_o    = host_we_i[i];
                    ram_be_o    = host_be_i[i];
                    ram_addr_o  = host_addr_i[i];
                    ram_wdata_o = host_wdata_i[i];
                end
            end
        end
    end

    always_comb begin
        host_rvalid_o = '0;
        for (int i = 0; i < NumHosts; i++) begin
            host_rvalid_o[i] = ram_rvalid_i && tag_vld && !rst_i && (tag_id == HostIdW'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= RUN;
            rr_ptr   <= '0;
            clr_cnt  <= '0;
            tag_vld  <= 1'b0;
            tag_id   <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            // Clear writes leave tag_vld low, so their responses go nowhere.
            tag_vld  <= |host_gnt_o;
            tag_id   <= gnt_id;
            case (state)
                RUN: begin
                    if (|host_gnt_o) begin
                        rr_ptr <= (gnt_id == HostIdW'(NumHosts - 1)) ? '0 : gnt_id + HostIdW'(1);
                    end
                    if (clr_req_i) state <= CLEAR;
                end
                CLEAR: begin
                    if (clr_cnt == CntW'(Depth - 1)) begin
                        clr_cnt  <= '0;
                        clr_done <= 1'b1;
                        state    <= RUN;
                    end else begin
                        clr_cnt <= clr_cnt + CntW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arb.sv
// Randomised + directed bench for ram_port_arb with a behavioural RAM, reference model and response scoreboard.
module tb_ram_port_arb;

    localparam int N = 2;
    localparam int D = 128;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [N-1:0]         host_req_i, host_we_i;
    logic [N-1:0][3:0]    host_be_i;
    logic [N-1:0][31:0]   host_addr_i, host_wdata_i;
    logic [N-1:0]         host_gnt_o, host_rvalid_o;
    logic [31:0]          host_rdata_o;
    logic                 ram_req_o, ram_we_o;
    logic [3:0]           ram_be_o;
    logic [31:0]          ram_addr_o, ram_wdata_o;
    logic                 ram_rvalid_i;
    logic [31:0]          ram_rdata_i;
    logic                 clr_req_i, clr_busy_o, clr_done_o;
    logic                 inject_rv;

    ram_port_arb #(.NumHosts(N), .Depth(D)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .host_req_i   (host_req_i),
        .host_we_i    (host_we_i),
        .host_be_i    (host_be_i),
        .host_addr_i  (host_addr_i),
        .host_wdata_i (host_wdata_i),
        .host_gnt_o   (host_gnt_o),
        .host_rvalid_o(host_rvalid_o),
        .host_rdata_o (host_rdata_o),
        .ram_req_o    (ram_req_o),
        .ram_we_o     (ram_we_o),
        .ram_be_o     (ram_be_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_rvalid_i (ram_rvalid_i),
        .ram_rdata_i  (ram_rdata_i),
        .clr_req_i    (clr_req_i),
        .clr_busy_o   (clr_busy_o),
        .clr_done_o   (clr_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          host;
        int          cyc;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] dev_mem [D];
    logic [31:0] ref_mem [D];

    // staged stimulus
    logic               s_rst, s_clr, s_inject;
    logic [N-1:0]       s_req, s_we;
    logic [N-1:0][3:0]  s_be;
    logic [N-1:0][31:0] s_addr, s_wd;

    // reference model state
    int           rr_next = 0;
    bit           m_clear = 0;
    int           m_cnt = 0;
    bit           done_pend = 0;
    logic [N-1:0] exp_gnt;

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural RAM: answers every access one cycle later
    always @(posedge clk) begin
        ram_rvalid_i <= ram_req_o | inject_rv;
        ram_rdata_i  <= dev_mem[ram_addr_o[8:2]];
        if (ram_req_o && ram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_be_o[b]) dev_mem[ram_addr_o[8:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (|host_rvalid_o) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rvalid_unexpected: got %b expected none (cycle %0d)", host_rvalid_o, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rvalid_host", 32'(host_rvalid_o), 32'(1) << e.host);
                chk("rvalid_cycle", cyc, e.cyc);
                if (e.rd) chk("rdata", host_rdata_o, e.data);
            end
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            exp_t m;
            m = q.pop_front();
            checks++;
            failures++;
            $display("FAIL rvalid_missing: host %0d got nothing expected rvalid at cycle %0d", m.host, m.cyc);
        end
    end

    task automatic step();
        logic [N-1:0] eg;
        logic         er, ewe, ebusy, edone;
        logic [3:0]   ebe;
        logic [31:0]  ea, ewd;
        int           g, w;
        bit           dn;
        @(posedge clk);
        #1;
        rst_i = s_rst; host_req_i = s_req; host_we_i = s_we; host_be_i = s_be;
        host_addr_i = s_addr; host_wdata_i = s_wd; clr_req_i = s_clr; inject_rv = s_inject;
        @(negedge clk);
        eg = '0; er = 0; ewe = 0; ebe = 0; ea = 0; ewd = 0; ebusy = 0; edone = 0; dn = 0;
        if (s_rst) begin
            rr_next = 0; m_clear = 0; m_cnt = 0;
            q.delete();
            chk("rvalid_in_reset", 32'(host_rvalid_o), 0);
        end else if (m_clear) begin
            er = 1; ewe = 1; ebe = 4'hF; ea = m_cnt * 4; ebusy = 1;
            ref_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == D) begin
                m_clear = 0; m_cnt = 0; dn = 1;
            end
        end else begin
            edone = done_pend;
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && s_req[(rr_next + k) % N]) g = (rr_next + k) % N;
            if (g >= 0) begin
                eg[g] = 1'b1; er = 1; ewe = s_we[g]; ebe = s_be[g]; ea = s_addr[g]; ewd = s_wd[g];
                w = int'(ea[8:2]);
                q.push_back('{host: g, cyc: cyc + 1, rd: !s_we[g], data: ref_mem[w]});
                if (s_we[g])
                    for (int b = 0; b < 4; b++)
                        if (ebe[b]) ref_mem[w][8*b +: 8] = ewd[8*b +: 8];
                rr_next = (g + 1) % N;
            end
            if (s_clr) m_clear = 1;
        end
        done_pend = dn;
        exp_gnt = eg;
        chk("host_gnt", 32'(host_gnt_o), 32'(eg));
        chk("ram_req", 32'(ram_req_o), 32'(er));
        chk("clr_busy", 32'(clr_busy_o), 32'(ebusy));
        chk("clr_done", 32'(clr_done_o), 32'(edone));
        if (er) begin
            chk("ram_addr", ram_addr_o, ea);
            chk("ram_we", 32'(ram_we_o), 32'(ewe));
            chk("ram_be", 32'(ram_be_o), 32'(ebe));
            chk("ram_wdata", ram_wdata_o, ewd);
        end
    endtask

    task automatic idle(input int n);
        s_req = '0; s_clr = 0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        s_req = '0; s_clr = 0; s_rst = 1;
        step();
        s_inject = 1;
        step();
        s_inject = 0; s_rst = 0;
    endtask

    task automatic refresh(input int i);
        s_req[i]  = ($urandom_range(0, 3) != 0);
        s_we[i]   = 1'($urandom_range(0, 1));
        s_be[i]   = 4'($urandom_range(1, 15));
        s_addr[i] = 32'($urandom_range(0, D - 1)) << 2;
        s_wd[i]   = $urandom;
    endtask

    initial begin
        rst_i = 1; host_req_i = '0; host_we_i = '0; host_be_i = '0; host_addr_i = '0;
        host_wdata_i = '0; clr_req_i = 0; inject_rv = 0;
        s_rst = 1; s_clr = 0; s_inject = 0; s_req = '0; s_we = '0; s_be = '0; s_addr = '0; s_wd = '0;
        for (int i = 0; i < D; i++) begin
            dev_mem[i] = 32'(i) * 32'h01010101 ^ 32'hA5A5_0F0F;
            ref_mem[i] = dev_mem[i];
        end
        do_reset();
        idle(1);

        // both hosts read on four consecutive cycles
        s_req = 2'b11; s_we = 2'b00; s_be = '{4'hF, 4'hF};
        s_addr = '{32'h0000_0004, 32'h0000_0000};
        repeat (4) step();
        idle(2);

        // host1 partial write then read back
        s_req = 2'b10; s_we = 2'b10; s_be[1] = 4'h3; s_addr[1] = 32'h10; s_wd[1] = 32'hDEADBEEF;
        step();
        s_we = 2'b00;
        step();
        idle(2);

        // single clear pulse, full sweep
        s_clr = 1; step(); s_clr = 0;
        idle(131);

        // host0 coincident with clear; host1 waits out the sweep
        s_req = 2'b01; s_we = 2'b00; s_addr[0] = 32'h20; s_clr = 1;
        step();
        s_clr = 0; s_req = 2'b10; s_addr[1] = 32'h10;
        repeat (130) step();
        idle(2);

        // reset aborts the sweep at word 50, a new sweep restarts at 0
        s_clr = 1; step(); s_clr = 0;
        repeat (50) step();
        do_reset();
        s_clr = 1; step(); s_clr = 0;
        idle(131);

        // clear held high across the sweep and into RUN
        s_clr = 1;
        repeat (133) step();
        idle(131);

        // randomized traffic with occasional clears; hosts hold until granted
        for (int i = 0; i < N; i++) refresh(i);
        for (int n = 0; n < 400; n++) begin
            s_clr = ($urandom_range(0, 79) == 0);
            step();
            for (int i = 0; i < N; i++)
                if (exp_gnt[i] || !s_req[i]) refresh(i);
        end
        idle(132);

        chk("pending_responses", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
